// File: rtl/branch_resolve_if.sv
// Branch-queue handshake between decode/execute and branch_resolve, plus the
// redirect, GHR-restore and PHT-training return paths.
interface branch_resolve_if #(
  parameter int unsigned GHR_WIDTH = 20
);
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic                 alloc_pred;
  logic [31:0]          alloc_pc;
  logic [31:0]          alloc_target;
  logic [GHR_WIDTH-1:0] alloc_ghr;
  logic                 res_valid;
  logic                 res_take;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 ghr_rst_valid;
  logic [GHR_WIDTH-1:0] ghr_rst_value;
  logic                 upd_valid;
  logic [GHR_WIDTH-1:0] upd_index;
  logic                 upd_take;

  modport master (
    output alloc_valid, alloc_pred, alloc_pc, alloc_target, alloc_ghr, res_valid, res_take,
    input  alloc_ready, redirect_valid, redirect_pc, ghr_rst_valid, ghr_rst_value,
    input  upd_valid, upd_index, upd_take
  );

  modport slave (
    input  alloc_valid, alloc_pred, alloc_pc, alloc_target, alloc_ghr, res_valid, res_take,
    output alloc_ready, redirect_valid, redirect_pc, ghr_rst_valid, ghr_rst_value,
    output upd_valid, upd_index, upd_take
  );
endinterface

// File: rtl/branch_resolve.sv
// In-order branch queue: checks predictions at resolve, issues redirect/GHR restore and PHT
// training. Optional perf counters enabled by defining BRANCH_PERF_EN.
module branch_resolve #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned GHR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  branch_resolve_if.slave       br,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                  err_o,
  output logic [31:0]           br_count,
  output logic [31:0]           mis_count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0]   FullCnt = (PtrW+1)'(DEPTH);
  localparam logic [PtrW:0]   CntOne  = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [DEPTH-1:0]     pred_q;
  logic [31:0]          pc_q  [DEPTH];
  logic [31:0]          tgt_q [DEPTH];
  logic [GHR_WIDTH-1:0] ghr_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            full, empty, pop, push, mis;

  logic                 head_pred;
  logic [31:0]          head_pc, head_tgt;
  logic [GHR_WIDTH-1:0] head_ghr;

  logic                 redirect_valid_q, upd_valid_q, upd_take_q;
  logic [31:0]          redirect_pc_q;
  logic [GHR_WIDTH-1:0] ghr_rst_value_q, upd_index_q;

  always_comb begin
    head_pred = pred_q[head_q];
    head_pc   = pc_q[head_q];
    head_tgt  = tgt_q[head_q];
    head_ghr  = ghr_q[head_q];

    full  = (count_q == FullCnt);
    empty = (count_q == '0);
    pop   = !flush_i && br.res_valid && !empty;
    mis   = pop && (head_pred != br.res_take);
    // A mispredict makes any same-cycle alloc wrong-path; a pop frees a slot when full.
    push  = !flush_i && br.alloc_valid && !mis && (!full || pop);

    err_d = err_q;
    if (!flush_i && ((br.alloc_valid && full && !pop) || (br.res_valid && empty))) begin
      err_d = 1'b1;
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      tail_d  = head_q;
      count_d = '0;
    end else if (mis) begin
      head_d  = head_q + PtrOne;
      tail_d  = head_q + PtrOne;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PtrOne;
      if (push) tail_d = tail_q + PtrOne;
      if (push && !pop) begin
        count_d = count_q + CntOne;
      end else if (pop && !push) begin
        count_d = count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        tgt_q[i] <= '0;
        ghr_q[i] <= '0;
      end
    end else if (push) begin
      pred_q[tail_q] <= br.alloc_pred;
      pc_q[tail_q]   <= br.alloc_pc;
      tgt_q[tail_q]  <= br.alloc_target;
      ghr_q[tail_q]  <= br.alloc_ghr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      ghr_rst_value_q  <= '0;
      upd_valid_q      <= 1'b0;
      upd_index_q      <= '0;
      upd_take_q       <= 1'b0;
    end else begin
      upd_valid_q      <= pop;
      redirect_valid_q <= mis;
      if (pop) begin
        upd_index_q <= head_ghr ^ head_pc[GHR_WIDTH+10:11];
        upd_take_q  <= br.res_take;
      end
      if (mis) begin
        redirect_pc_q   <= br.res_take ? head_tgt : head_pc + 32'd4;
        ghr_rst_value_q <= {head_ghr[GHR_WIDTH-2:0], br.res_take};
      end
    end
  end

  assign br.alloc_ready    = !full;
  assign br.redirect_valid = redirect_valid_q;
  assign br.redirect_pc    = redirect_pc_q;
  assign br.ghr_rst_valid  = redirect_valid_q;
  assign br.ghr_rst_value  = ghr_rst_value_q;
  assign br.upd_valid      = upd_valid_q;
  assign br.upd_index      = upd_index_q;
  assign br.upd_take       = upd_take_q;
  assign occupancy         = count_q;
  assign err_o             = err_q;

`ifdef BRANCH_PERF_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  // Saturating counters fed by the registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (upd_valid_q && (br_cnt_q != 32'hFFFF_FFFF))       br_cnt_q  <= br_cnt_q + 32'd1;
      if (redirect_valid_q && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign br_count  = br_cnt_q;
  assign mis_count = mis_cnt_q;
`else
  assign br_count  = '0;
  assign mis_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: queue-based reference model, directed cases then random.
module tb_branch_resolve;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GW    = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;
  logic err_o;
  logic [31:0] br_count, mis_count;

  branch_resolve_if #(.GHR_WIDTH(GW)) bif ();

  branch_resolve #(.DEPTH(DEPTH), .GHR_WIDTH(GW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .br        (bif),
    .occupancy (occupancy),
    .err_o     (err_o),
    .br_count  (br_count),
    .mis_count (mis_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pred;
    bit [31:0]   pc;
    bit [31:0]   tgt;
    bit [GW-1:0] ghr;
  } ent_t;

  typedef struct {
    bit          upd;
    bit [GW-1:0] idx;
    bit          take;
    bit          mis;
    bit [31:0]   rpc;
    bit [GW-1:0] gval;
    int unsigned occ;
    bit          err;
  } exp_t;

  ent_t        model_q[$];
  exp_t        exp_q[$];
  bit          m_err;
  int unsigned m_br, m_mis;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic set_idle();
    flush_i          = 1'b0;
    bif.alloc_valid  = 1'b0;
    bif.alloc_pred   = 1'b0;
    bif.alloc_pc     = '0;
    bif.alloc_target = '0;
    bif.alloc_ghr    = '0;
    bif.res_valid    = 1'b0;
    bif.res_take     = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue the response the model predicts for it.
  task automatic step(input bit fl, input bit av, input bit ap, input logic [31:0] apc,
                      input logic [31:0] atg, input logic [GW-1:0] ag, input bit rv, input bit rt);
    exp_t e;
    ent_t h;
    @(negedge clk);
    flush_i          = fl;
    bif.alloc_valid  = av;
    bif.alloc_pred   = ap;
    bif.alloc_pc     = apc;
    bif.alloc_target = atg;
    bif.alloc_ghr    = ag;
    bif.res_valid    = rv;
    bif.res_take     = rt;
    e = '{default: '0};
    if (fl) begin
      model_q.delete();
    end else begin
      if (rv) begin
        if (model_q.size() == 0) begin
          m_err = 1'b1;
        end else begin
          h      = model_q.pop_front();
          e.upd  = 1'b1;
          e.take = rt;
          e.idx  = h.ghr ^ h.pc[GW+10:11];
          m_br++;
          if (h.pred != rt) begin
            e.mis  = 1'b1;
            e.rpc  = rt ? h.tgt : h.pc + 32'd4;
            e.gval = {h.ghr[GW-2:0], rt};
            model_q.delete();
            m_mis++;
          end
        end
      end
      if (av && !e.mis) begin
        if (model_q.size() < DEPTH) model_q.push_back('{pred: ap, pc: apc, tgt: atg, ghr: ag});
        else m_err = 1'b1;
      end
    end
    e.occ = model_q.size();
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic alloc(input logic [31:0] pc, input bit pred, input logic [31:0] tgt,
                       input logic [GW-1:0] ghr);
    step(1'b0, 1'b1, pred, pc, tgt, ghr, 1'b0, 1'b0);
  endtask

  task automatic resolve(input bit take);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0, 1'b1, take);
  endtask

  task automatic drain();
    @(negedge clk);
    set_idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset();
    chk("rst_occupancy", occupancy, 0);
    chk("rst_err_o", err_o, 0);
    chk("rst_upd_valid", bif.upd_valid, 0);
    chk("rst_redirect_valid", bif.redirect_valid, 0);
    chk("rst_ghr_rst_valid", bif.ghr_rst_valid, 0);
    chk("rst_redirect_pc", bif.redirect_pc, 0);
    chk("rst_ghr_rst_value", bif.ghr_rst_value, 0);
    chk("rst_upd_index", bif.upd_index, 0);
    chk("rst_br_count", br_count, 0);
    chk("rst_mis_count", mis_count, 0);
    chk("rst_alloc_ready", bif.alloc_ready, 1);
  endtask

  // Assert reset mid-cycle and check the clear happens before any clock edge.
  task automatic do_reset();
    drain();
    #2 rst_n = 1'b0;
    #1 chk_reset();
    model_q.delete();
    m_err = 1'b0;
    m_br  = 0;
    m_mis = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_perf(input string tag);
    drain();
    repeat (3) @(negedge clk);
`ifdef BRANCH_PERF_EN
    chk({tag, "_br_count"}, br_count, m_br);
    chk({tag, "_mis_count"}, mis_count, m_mis);
`else
    chk({tag, "_br_count"}, br_count, 0);
    chk({tag, "_mis_count"}, mis_count, 0);
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("upd_valid", bif.upd_valid, e.upd);
          if (e.upd) begin
            chk("upd_index", bif.upd_index, e.idx);
            chk("upd_take", bif.upd_take, e.take);
          end
          chk("redirect_valid", bif.redirect_valid, e.mis);
          chk("ghr_rst_valid", bif.ghr_rst_valid, e.mis);
          if (e.mis) begin
            chk("redirect_pc", bif.redirect_pc, e.rpc);
            chk("ghr_rst_value", bif.ghr_rst_value, e.gval);
          end
          chk("occupancy", occupancy, e.occ);
          chk("err_o", err_o, e.err);
          chk("alloc_ready", bif.alloc_ready, e.occ != DEPTH);
        end else begin
          chk("idle_upd_valid", bif.upd_valid, 0);
          chk("idle_redirect_valid", bif.redirect_valid, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    set_idle();
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;

    // Correctly predicted taken branch.
    alloc(32'h100, 1'b1, 32'h200, '0);
    resolve(1'b1);
    // Predicted taken, actually not taken.
    alloc(32'h400, 1'b1, 32'h800, 20'h5A5A5);
    resolve(1'b0);
    // Three in flight, oldest mispredicts, then resolve on empty queue.
    alloc(32'h1000, 1'b0, 32'h2000, 20'h00011);
    alloc(32'h1004, 1'b1, 32'h3000, 20'h00022);
    alloc(32'h1008, 1'b1, 32'h4000, 20'h00044);
    resolve(1'b1);
    resolve(1'b0);
    check_perf("dir1");

    // Fill, overflow, then alloc+res while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(32'h8000 + 32'(i * 16), 1'b1, 32'h9000, GW'(i));
    alloc(32'hDEAD0, 1'b1, 32'h0, '1);
    step(1'b0, 1'b1, 1'b0, 32'hA000, 32'hB000, 20'h12345, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) resolve(1'b1);

    // Flush with a resolve and alloc in the same cycle.
    do_reset();
    alloc(32'h500, 1'b1, 32'h600, 20'h00F0F);
    alloc(32'h504, 1'b0, 32'h700, 20'h0F0F0);
    step(1'b1, 1'b1, 1'b1, 32'h508, 32'h900, 20'h1, 1'b1, 1'b0);
    resolve(1'b1);

    // Ten resolves, three of them mispredicted.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      alloc(32'h4_0000 + 32'(i * 4), 1'b1, 32'h5_0000 + 32'(i * 8), GW'(i * 3));
      resolve((i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1);
    end
    check_perf("ten");

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, GW'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 65);
    end
    check_perf("rand");

    // Async reset while traffic is in flight.
    alloc(32'h700, 1'b1, 32'h800, 20'h3);
    alloc(32'h704, 1'b0, 32'h900, 20'h4);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
